// File: rtl/dram_timing_ctrl.sv
// DRAM strobe sequencer: turns oversampled Z80 memory/refresh cycles into per-bank RAS,
// shared CAS, address-mux select and write enable with programmable inter-strobe delays.
module dram_timing_ctrl #(
    parameter int unsigned NUM_BANKS  = 2,
    parameter int unsigned RAS_TO_MUX = 1,
    parameter int unsigned MUX_TO_CAS = 1,
    parameter int unsigned PRECHARGE  = 2,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 nmreq,
    input  logic                 nrd,
    input  logic                 nwr,
    input  logic                 nrfsh,
    input  logic [NUM_BANKS-1:0] nsltsl,
    output logic [NUM_BANKS-1:0] nras,
    output logic                 ncas,
    output logic                 mux,
    output logic                 nwe,
    output logic                 busy
);

    typedef enum logic [2:0] {
        StIdle,
        StRas,
        StMux,
        StCas,
        StRefresh,
        StPrecharge
    } state_e;

    localparam logic [CNT_W-1:0] RasLoad = CNT_W'(RAS_TO_MUX - 1);
    localparam logic [CNT_W-1:0] MuxLoad = CNT_W'(MUX_TO_CAS - 1);
    localparam logic [CNT_W-1:0] PreLoad = CNT_W'(PRECHARGE - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_BANKS-1:0] nras_q, nras_d;
    logic                 ncas_q, ncas_d;
    logic                 mux_q, mux_d;
    logic                 nwe_q, nwe_d;
    logic                 go_pre;

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        nras_d  = nras_q;
        ncas_d  = ncas_q;
        mux_d   = mux_q;
        nwe_d   = nwe_q;
        go_pre  = 1'b0;

        unique case (state_q)
            StIdle: begin
                nras_d = '1;
                ncas_d = 1'b1;
                mux_d  = 1'b0;
                nwe_d  = 1'b1;
                if (!nmreq && !nrfsh) begin
                    state_d = StRefresh;
                    nras_d  = '0;
                end else if (!nmreq && (nsltsl != '1)) begin
                    // nras_q doubles as the latched bank mask for the whole access.
                    state_d = StRas;
                    nras_d  = nsltsl;
                    cnt_d   = RasLoad;
                end
            end
            StRas: begin
                if (nmreq) begin
                    go_pre = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = StMux;
                    mux_d   = 1'b1;
                    cnt_d   = MuxLoad;
                end
            end
            StMux: begin
                if (nmreq) begin
                    go_pre = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = StCas;
                    ncas_d  = nrd & nwr;
                    nwe_d   = nwr;
                end
            end
            StCas: begin
                if (nmreq) begin
                    go_pre = 1'b1;
                end else begin
                    ncas_d = nrd & nwr;
                    nwe_d  = nwr;
                end
            end
            StRefresh: begin
                if (nmreq) begin
                    go_pre = 1'b1;
                end
            end
            StPrecharge: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (go_pre) begin
            state_d = StPrecharge;
            nras_d  = '1;
            ncas_d  = 1'b1;
            mux_d   = 1'b0;
            nwe_d   = 1'b1;
            cnt_d   = PreLoad;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            nras_q  <= '1;
            ncas_q  <= 1'b1;
            mux_q   <= 1'b0;
            nwe_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nras_q  <= nras_d;
            ncas_q  <= ncas_d;
            mux_q   <= mux_d;
            nwe_q   <= nwe_d;
        end
    end

    assign nras = nras_q;
    assign ncas = ncas_q;
    assign mux  = mux_q;
    assign nwe  = nwe_q;
    assign busy = (state_q != StIdle);

endmodule
